// File: rtl/instr_mem_responder_if.sv
// Fetch-stage instruction bus: request/grant/address out, in-order response beats back.
// Signal suffixes are written from the responder's point of view.
interface instr_mem_responder_if;
    logic        instr_req_i;
    logic        instr_gnt_o;
    logic [31:0] instr_addr_i;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        instr_rvalid_o;

    modport slave (
        input  instr_req_i,
        input  instr_addr_i,
        output instr_gnt_o,
        output instr_rdata_o,
        output instr_err_o,
        output instr_rvalid_o
    );

    modport master (
        output instr_req_i,
        output instr_addr_i,
        input  instr_gnt_o,
        input  instr_rdata_o,
        input  instr_err_o,
        input  instr_rvalid_o
    );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: grants fetch reads up to an outstanding limit, answers them
// in order after a fixed latency, flags out-of-range addresses, and takes program-load writes.
module instr_mem_responder #(
    parameter int          MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter              INIT_FILE       = ""
) (
    input  logic                  clk,
    input  logic                  rstn,
    instr_mem_responder_if.slave  bus,
    input  logic                  prog_we_i,
    input  logic [31:0]           prog_addr_i,
    input  logic [31:0]           prog_wdata_i,
    output logic                  busy_o
);

    localparam int              AW      = $clog2(MEM_WORDS);
    localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] data;
    } beat_t;

    // Address decode: a borrow out of the subtraction means below BASE_ADDR,
    // any set bit above the index field means past the end of the RAM.
    logic [32:0]   req_off;
    logic [32:0]   prog_off;
    logic          req_hit;
    logic          prog_hit;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] prog_idx;
    logic          unused_addr_bits;

    assign req_off  = {1'b0, bus.instr_addr_i} - {1'b0, BASE_ADDR};
    assign prog_off = {1'b0, prog_addr_i}      - {1'b0, BASE_ADDR};
    assign req_hit  = (req_off[32:AW+2]  == '0);
    assign prog_hit = (prog_off[32:AW+2] == '0);
    assign req_idx  = req_off[AW+1:2];
    assign prog_idx = prog_off[AW+1:2];
    assign unused_addr_bits = ^{req_off[1:0], prog_off[1:0]};

    // Instruction RAM
    logic [31:0] mem_q [MEM_WORDS];

    // NOTE: the RAM is deliberately left out of reset; clearing a memory array needs a
    // write port per word, and software always loads the program before fetching it.
    always_ff @(posedge clk) begin
        if (prog_we_i && prog_hit) begin
            mem_q[prog_idx] <= prog_wdata_i;
        end
    end

    // Grant and handshake
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          handshake;
    logic          rvalid;

    assign bus.instr_gnt_o = bus.instr_req_i && !prog_we_i && (cnt_q < MAX_CNT);
    assign handshake       = bus.instr_req_i && bus.instr_gnt_o;

    // Latency pipe: stage 0 captures the RAM word on the accept edge, so a later
    // program write to the same word cannot change a read already in flight.
    beat_t beat_d;
    beat_t pipe_q [LATENCY];

    // NOTE: every variable gets its default before any branch, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        beat_d = '0;
        if (handshake) begin
            beat_d.vld  = 1'b1;
            beat_d.err  = !req_hit;
            beat_d.data = req_hit ? mem_q[req_idx] : 32'h0;
        end
    end

    // NOTE: non-blocking assignments make each stage take its predecessor's value from
    // before the edge; blocking ones would collapse the shift register into one stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= beat_d;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Invalid beats carry zero data and err, so the outputs are zero whenever rvalid is low.
    assign rvalid             = pipe_q[LATENCY-1].vld;
    assign bus.instr_rvalid_o = rvalid;
    assign bus.instr_err_o    = pipe_q[LATENCY-1].err;
    assign bus.instr_rdata_o  = pipe_q[LATENCY-1].data;

    // Outstanding counter
    always_comb begin
        cnt_d = cnt_q;
        unique case ({handshake, rvalid})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rstn) cnt_q <= MAX_CNT);
    a_no_orphan: assert property (@(posedge clk) disable iff (!rstn) rvalid |-> cnt_q != '0);
    a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rstn)
                                      bus.instr_gnt_o |-> bus.instr_req_i);

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two instances (LATENCY=1 at base 0; LATENCY=3, 16 words at 0x1000)
// driven cycle by cycle, with a RAM model and per-instance response scoreboards.
module tb_instr_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        req        [2];
    logic [31:0] addr       [2];
    logic        gnt        [2];
    logic [31:0] rdata      [2];
    logic        err        [2];
    logic        rvalid     [2];
    logic        prog_we    [2];
    logic [31:0] prog_addr  [2];
    logic [31:0] prog_wdata [2];
    logic        busy       [2];

    instr_mem_responder_if bus_a ();
    instr_mem_responder_if bus_b ();

    assign bus_a.instr_req_i  = req[0];
    assign bus_a.instr_addr_i = addr[0];
    assign bus_b.instr_req_i  = req[1];
    assign bus_b.instr_addr_i = addr[1];
    assign gnt[0]    = bus_a.instr_gnt_o;
    assign rdata[0]  = bus_a.instr_rdata_o;
    assign err[0]    = bus_a.instr_err_o;
    assign rvalid[0] = bus_a.instr_rvalid_o;
    assign gnt[1]    = bus_b.instr_gnt_o;
    assign rdata[1]  = bus_b.instr_rdata_o;
    assign err[1]    = bus_b.instr_err_o;
    assign rvalid[1] = bus_b.instr_rvalid_o;

    instr_mem_responder #(
        .MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2), .INIT_FILE("")
    ) u_dut_a (
        .clk(clk), .rstn(rstn), .bus(bus_a),
        .prog_we_i(prog_we[0]), .prog_addr_i(prog_addr[0]), .prog_wdata_i(prog_wdata[0]),
        .busy_o(busy[0])
    );

    instr_mem_responder #(
        .MEM_WORDS(16), .BASE_ADDR(32'h1000), .LATENCY(3), .MAX_OUTSTANDING(2), .INIT_FILE("")
    ) u_dut_b (
        .clk(clk), .rstn(rstn), .bus(bus_b),
        .prog_we_i(prog_we[1]), .prog_addr_i(prog_addr[1]), .prog_wdata_i(prog_wdata[1]),
        .busy_o(busy[1])
    );

    localparam int    LAT   [2] = '{1, 3};
    localparam int    MAXO  [2] = '{2, 2};
    localparam int    WORDS [2] = '{1024, 16};
    localparam longint BASE [2] = '{64'h0, 64'h1000};

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb [2][$];
    int          out_m [2];
    logic        rv_m  [2];
    logic [31:0] mem_m [2][1024];
    int          now_cyc;
    int          checks;
    int          failures;

    function automatic logic hit_m(input int d, input logic [31:0] a);
        longint off;
        off = longint'(a) - BASE[d];
        return (off >= 0) && (off < 4 * longint'(WORDS[d]));
    endfunction

    function automatic int idx_m(input int d, input logic [31:0] a);
        return int'((longint'(a) - BASE[d]) >>> 2);
    endfunction

    function automatic string tag(input int k, input string name);
        return $sformatf("%s.%s@%0d", (k == 0) ? "a" : "b", name, now_cyc);
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp_v);
        end
    endtask

    // Compare the registered outputs of instance k against the scoreboard head.
    task automatic check_outputs(input int k);
        logic exp_rv;
        exp_t e;
        exp_rv = (sb[k].size() > 0) && (sb[k][0].due == now_cyc);
        check(tag(k, "rvalid"), 32'(rvalid[k]), 32'(exp_rv));
        if (exp_rv) begin
            e = sb[k].pop_front();
            check(tag(k, "rdata"), rdata[k], e.data);
            check(tag(k, "err"), 32'(err[k]), 32'(e.err));
        end else begin
            check(tag(k, "idle_rdata"), rdata[k], 32'h0);
            check(tag(k, "idle_err"), 32'(err[k]), 32'h0);
        end
        check(tag(k, "busy"), 32'(busy[k]), 32'(out_m[k] != 0));
        rv_m[k] = exp_rv;
    endtask

    // One clock: check both instances, drive instance d, check grants, update the models.
    task automatic step(input int d, input logic rq, input logic [31:0] ra,
                        input logic we, input logic [31:0] wa, input logic [31:0] wd,
                        output logic granted);
        logic eg;
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_outputs(k);
        for (int k = 0; k < 2; k++) begin
            req[k]     = 1'b0;
            prog_we[k] = 1'b0;
        end
        req[d]        = rq;
        addr[d]       = ra;
        prog_we[d]    = we;
        prog_addr[d]  = wa;
        prog_wdata[d] = wd;
        #1;
        granted = 1'b0;
        for (int k = 0; k < 2; k++) begin
            eg = req[k] && !prog_we[k] && (out_m[k] < MAXO[k]);
            check(tag(k, "gnt"), 32'(gnt[k]), 32'(eg));
            if (eg) begin
                e.err  = !hit_m(k, addr[k]);
                e.data = e.err ? 32'h0 : mem_m[k][idx_m(k, addr[k])];
                e.due  = now_cyc + LAT[k];
                sb[k].push_back(e);
            end
            if (k == d) granted = eg;
            out_m[k] = out_m[k] + int'(eg) - int'(rv_m[k]);
            if (prog_we[k] && hit_m(k, prog_addr[k])) begin
                mem_m[k][idx_m(k, prog_addr[k])] = prog_wdata[k];
            end
        end
        now_cyc++;
    endtask

    task automatic idle(input int n);
        logic g;
        for (int i = 0; i < n; i++) step(0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, g);
    endtask

    task automatic write_word(input int d, input logic [31:0] wa, input logic [31:0] wd);
        logic g;
        step(d, 1'b0, 32'h0, 1'b1, wa, wd, g);
    endtask

    task automatic read_word(input int d, input logic [31:0] ra);
        logic g;
        step(d, 1'b1, ra, 1'b0, 32'h0, 32'h0, g);
    endtask

    // Fetch-style stream: req held high, address advances only when granted.
    task automatic fetch_stream(input int d, input logic [31:0] base, input int n);
        logic g;
        int   i;
        int   guard;
        i = 0;
        guard = 0;
        while (i < n && guard < 40) begin
            step(d, 1'b1, base + 32'(4 * i), 1'b0, 32'h0, 32'h0, g);
            if (g) i++;
            guard++;
        end
        check($sformatf("stream%0d.granted", d), 32'(i), 32'(n));
    endtask

    task automatic check_reset_outputs(input string name);
        for (int k = 0; k < 2; k++) begin
            check(tag(k, {name, "_rvalid"}), 32'(rvalid[k]), 32'h0);
            check(tag(k, {name, "_rdata"}), rdata[k], 32'h0);
            check(tag(k, {name, "_err"}), 32'(err[k]), 32'h0);
            check(tag(k, {name, "_busy"}), 32'(busy[k]), 32'h0);
            check(tag(k, {name, "_gnt"}), 32'(gnt[k]), 32'h0);
        end
    endtask

    task automatic reset_mid();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            req[k]     = 1'b0;
            prog_we[k] = 1'b0;
        end
        #2 rstn = 1'b0;
        #1 check_reset_outputs("rst_mid");
        for (int k = 0; k < 2; k++) begin
            sb[k].delete();
            out_m[k] = 0;
            rv_m[k]  = 1'b0;
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic g;
        checks   = 0;
        failures = 0;
        now_cyc  = 0;
        rstn     = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; addr[k] = 32'h0; prog_we[k] = 1'b0;
            prog_addr[k] = 32'h0; prog_wdata[k] = 32'h0;
            out_m[k] = 0; rv_m[k] = 1'b0;
        end

        #3 check_reset_outputs("rst");
        @(negedge clk);
        rstn = 1'b1;

        // LATENCY=1: single read returns next cycle
        write_word(0, 32'h0, 32'h0000_0013);
        read_word(0, 32'h0);
        idle(2);

        // LATENCY=1: back-to-back grants give back-to-back beats
        write_word(0, 32'h4, 32'hA5A5_0004);
        write_word(0, 32'h8, 32'hA5A5_0008);
        write_word(0, 32'hC, 32'hA5A5_000C);
        fetch_stream(0, 32'h0, 4);
        idle(2);

        // LATENCY=3, two outstanding: third request stalls until a beat retires
        write_word(1, 32'h1000, 32'h1111_0000);
        write_word(1, 32'h1004, 32'h1111_0001);
        write_word(1, 32'h1008, 32'h1111_0002);
        write_word(1, 32'h103C, 32'h1111_000F);
        fetch_stream(1, 32'h1000, 3);
        idle(5);

        // Range: one past the end, last word via unaligned address, just below base
        read_word(1, 32'h1040);
        read_word(1, 32'h103E);
        read_word(1, 32'h0FFC);
        idle(5);

        // Out-of-range write must not alias onto word 0
        write_word(1, 32'h1040, 32'hBAD0_BAD0);
        read_word(1, 32'h1000);
        idle(4);

        // Program write blocks the same-cycle request; next cycle reads the new word
        step(0, 1'b1, 32'h10, 1'b1, 32'h10, 32'hDEAD_BEEF, g);
        read_word(0, 32'h10);
        idle(2);

        // Write after accept: the in-flight read keeps the old word
        write_word(1, 32'h1020, 32'h1111_1111);
        read_word(1, 32'h1020);
        write_word(1, 32'h1020, 32'h2222_2222);
        idle(4);
        read_word(1, 32'h1020);
        idle(4);

        // Reset with two reads in flight: no stale beat afterwards
        read_word(1, 32'h1000);
        read_word(1, 32'h1004);
        reset_mid();
        read_word(1, 32'h1008);
        idle(5);

        for (int k = 0; k < 2; k++) begin
            check(tag(k, "drained"), 32'(sb[k].size()), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
